// File: rtl/depacketizer_pkg.sv
// Shared types and defaults for the HSI stream depacketizer.
package depacketizer_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEFAULT_PKT_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RECV  = 2'b01,
        DRAIN = 2'b10,
        DROP  = 2'b11
    } state_t;

endpackage

// File: rtl/depacketizer_if.sv
// Inbound AXI-Stream style link carrying packet beats into the depacketizer.
interface depacketizer_if;
    import depacketizer_pkg::*;

    logic [WORD_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, input  s_tlast, output s_tready);

endinterface

// File: rtl/depacketizer_pkt_buffer.sv
// One-packet register file: synchronous write port, registered read port.
module pkt_buffer
    import depacketizer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_PKT_LEN,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/depacketizer.sv
// Receives fixed-length stream packets, checks length, and replays good ones
// as one-word-per-cycle strobes; malformed packets are dropped and counted.
module depacketizer
    import depacketizer_pkg::*;
#(
    parameter int unsigned PKT_LEN = DEFAULT_PKT_LEN,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    depacketizer_if.slave     s,
    output logic [WORD_W-1:0] data_out,
    output logic              valid,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  pkt_good,
    output logic [CNT_W-1:0]  pkt_bad
);

    localparam int unsigned      IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    state_t           state;
    logic             tready_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             accept;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign s.s_tready = tready_q;
    assign accept     = s.s_tvalid & tready_q;
    assign wr_en      = accept & ((state == IDLE) | (state == RECV));
    assign rd_en      = (state == DRAIN);

    // The buffer's read register is the data_out register.
    pkt_buffer #(
        .DEPTH (PKT_LEN),
        .AW    (IDX_W)
    ) u_pkt_buffer (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (s.s_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (data_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tready_q  <= 1'b1;
            valid     <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            pkt_good  <= '0;
            pkt_bad   <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
        end else begin
            valid     <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                IDLE, RECV: begin
                    if (accept) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            if (s.s_tlast) begin
                                state    <= DRAIN;
                                tready_q <= 1'b0;
                            end else begin
                                state    <= DROP;
                            end
                        end else if (s.s_tlast) begin
                            err_short <= 1'b1;
                            pkt_bad   <= sat_inc(pkt_bad);
                            wr_idx    <= '0;
                            state     <= IDLE;
                        end else begin
                            wr_idx    <= wr_idx + IDX_W'(1);
                            state     <= RECV;
                        end
                    end
                end
                DRAIN: begin
                    valid <= 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        rd_idx   <= '0;
                        pkt_good <= sat_inc(pkt_good);
                        tready_q <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rd_idx   <= rd_idx + IDX_W'(1);
                    end
                end
                DROP: begin
                    // Overlong packet: swallow beats until its TLAST.
                    if (accept && s.s_tlast) begin
                        err_long <= 1'b1;
                        pkt_bad  <= sat_inc(pkt_bad);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Self-checking bench for depacketizer: randomized packets against a packet-level model.
module tb_depacketizer;

    localparam int PKT_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       data_out;
    logic              valid;
    logic              err_short;
    logic              err_long;
    logic [CNT_W-1:0]  pkt_good;
    logic [CNT_W-1:0]  pkt_bad;

    always #5 clock = ~clock;

    depacketizer_if ifc ();

    depacketizer #(.PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .s         (ifc),
        .data_out  (data_out),
        .valid     (valid),
        .err_short (err_short),
        .err_long  (err_long),
        .pkt_good  (pkt_good),
        .pkt_bad   (pkt_bad)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: samples outputs 1 time unit after each rising edge.
    int          cyc = 0;
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    int          n_short_seen = 0;
    int          n_long_seen  = 0;
    int          n_busy       = 0;
    int          short_cyc    = -1;
    int          long_cyc     = -1;

    always @(posedge clock) begin
        #1;
        cyc++;
        if (reset_n) begin
            if (valid) begin
                rx_q.push_back(data_out);
                rx_cyc.push_back(cyc);
            end
            if (err_short) begin n_short_seen++; short_cyc = cyc; end
            if (err_long)  begin n_long_seen++;  long_cyc  = cyc; end
            if (!ifc.s_tready) n_busy++;
        end
    end

    // Packet-level reference model.
    logic [31:0] exp_q[$];
    int exp_good  = 0;
    int exp_bad   = 0;
    int exp_short = 0;
    int exp_long  = 0;
    int last_acc_cyc = 0;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic beat(input logic [31:0] d, input bit last);
        int t = 0;
        ifc.s_tdata  = d;
        ifc.s_tvalid = 1'b1;
        ifc.s_tlast  = last;
        while (ifc.s_tready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL beat_accept: s_tready=%b, required 1 within 200 cycles", ifc.s_tready);
        end
        @(negedge clock);
    endtask

    // Drives one packet of len beats (called at a falling edge) and updates the model.
    task automatic send_pkt(input int len, input bit gaps, input logic [31:0] base, input bit rand_data);
        logic [31:0] w[$];
        for (int i = 0; i < len; i++) w.push_back(rand_data ? 32'($urandom) : base + 32'(i));
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                ifc.s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
            beat(w[i], i == len - 1);
        end
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        last_acc_cyc = cyc;
        if (len == PKT_LEN) begin
            foreach (w[i]) exp_q.push_back(w[i]);
            exp_good++;
        end else if (len < PKT_LEN) begin
            exp_bad++; exp_short++;
        end else begin
            exp_bad++; exp_long++;
        end
    endtask

    task automatic test_reset();
        ifc.s_tvalid = 1'b0; ifc.s_tlast = 1'b0; ifc.s_tdata = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (ifc.s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b want 1", ifc.s_tready); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b want 00", err_short, err_long); end
        n_checks++; if (pkt_good !== '0 || pkt_bad !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pkt_good, pkt_bad); end
        reset_n = 1'b1;
        exp_good = 0; exp_bad = 0;
        repeat (2) @(negedge clock);
        n_checks++; if (ifc.s_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b want 1", ifc.s_tready); end
    endtask

    task automatic test_good();
        int rb = rx_q.size(); int eb = exp_q.size(); int b0 = n_busy;
        int s0 = n_short_seen; int l0 = n_long_seen;
        send_pkt(PKT_LEN, 1'b0, 32'h1000, 1'b0);
        repeat (PKT_LEN + 3) @(negedge clock);
        n_checks++; if (rx_q.size() - rb != PKT_LEN) begin n_fail++; $display("FAIL good_count: got %0d want %0d", rx_q.size() - rb, PKT_LEN); end
        for (int k = 0; k < PKT_LEN && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL good_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
            n_checks++; if (rx_cyc[rb + k] != last_acc_cyc + 1 + k) begin n_fail++; $display("FAIL good_timing[%0d]: cycle %0d want %0d", k, rx_cyc[rb + k], last_acc_cyc + 1 + k); end
        end
        n_checks++; if (n_busy - b0 != PKT_LEN) begin n_fail++; $display("FAIL good_tready_low: got %0d cycles want %0d", n_busy - b0, PKT_LEN); end
        n_checks++; if (pkt_good !== CNT_W'(sat(exp_good))) begin n_fail++; $display("FAIL good_pkt_good: got %0d want %0d", pkt_good, sat(exp_good)); end
        n_checks++; if (n_short_seen != s0 || n_long_seen != l0) begin n_fail++; $display("FAIL good_no_err: got %0d/%0d extra pulses want 0/0", n_short_seen - s0, n_long_seen - l0); end
    endtask

    task automatic test_back_to_back();
        int rb = rx_q.size(); int eb = exp_q.size();
        int s0 = n_short_seen; int l0 = n_long_seen;
        send_pkt(PKT_LEN, 1'b0, 32'h0, 1'b1);
        send_pkt(PKT_LEN, 1'b0, 32'h0, 1'b1);
        repeat (PKT_LEN + 3) @(negedge clock);
        n_checks++; if (rx_q.size() - rb != 2 * PKT_LEN) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", rx_q.size() - rb, 2 * PKT_LEN); end
        for (int k = 0; k < 2 * PKT_LEN && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
        end
        n_checks++; if (pkt_good !== CNT_W'(sat(exp_good))) begin n_fail++; $display("FAIL b2b_pkt_good: got %0d want %0d", pkt_good, sat(exp_good)); end
        n_checks++; if (n_short_seen != s0 || n_long_seen != l0) begin n_fail++; $display("FAIL b2b_no_err: got %0d/%0d pulses want 0/0", n_short_seen - s0, n_long_seen - l0); end
    endtask

    task automatic test_short();
        int rb = rx_q.size(); int eb; int s0 = n_short_seen;
        send_pkt(5, 1'b0, 32'h2000, 1'b0);
        repeat (3) @(negedge clock);
        n_checks++; if (n_short_seen - s0 != 1) begin n_fail++; $display("FAIL short_pulse: got %0d pulses want 1", n_short_seen - s0); end
        n_checks++; if (short_cyc != last_acc_cyc) begin n_fail++; $display("FAIL short_timing: cycle %0d want %0d", short_cyc, last_acc_cyc); end
        n_checks++; if (rx_q.size() != rb) begin n_fail++; $display("FAIL short_no_valid: got %0d words want 0", rx_q.size() - rb); end
        n_checks++; if (pkt_bad !== CNT_W'(sat(exp_bad))) begin n_fail++; $display("FAIL short_pkt_bad: got %0d want %0d", pkt_bad, sat(exp_bad)); end
        eb = exp_q.size();
        send_pkt(PKT_LEN, 1'b0, 32'h3000, 1'b0);
        repeat (PKT_LEN + 3) @(negedge clock);
        n_checks++; if (rx_q.size() - rb != PKT_LEN) begin n_fail++; $display("FAIL short_follow_count: got %0d want %0d", rx_q.size() - rb, PKT_LEN); end
        for (int k = 0; k < PKT_LEN && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL short_follow_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
        end
    endtask

    task automatic test_long();
        int rb = rx_q.size(); int l0 = n_long_seen; int b0 = n_busy;
        send_pkt(PKT_LEN + 3, 1'b0, 32'h4000, 1'b0);
        repeat (3) @(negedge clock);
        n_checks++; if (n_long_seen - l0 != 1) begin n_fail++; $display("FAIL long_pulse: got %0d pulses want 1", n_long_seen - l0); end
        n_checks++; if (long_cyc != last_acc_cyc) begin n_fail++; $display("FAIL long_timing: cycle %0d want %0d", long_cyc, last_acc_cyc); end
        n_checks++; if (rx_q.size() != rb) begin n_fail++; $display("FAIL long_no_valid: got %0d words want 0", rx_q.size() - rb); end
        n_checks++; if (n_busy != b0) begin n_fail++; $display("FAIL long_tready: low %0d cycles want 0", n_busy - b0); end
        n_checks++; if (pkt_bad !== CNT_W'(sat(exp_bad))) begin n_fail++; $display("FAIL long_pkt_bad: got %0d want %0d", pkt_bad, sat(exp_bad)); end
    endtask

    task automatic test_gapped();
        int rb = rx_q.size(); int eb = exp_q.size();
        send_pkt(PKT_LEN, 1'b1, 32'h0, 1'b1);
        repeat (PKT_LEN + 3) @(negedge clock);
        n_checks++; if (rx_q.size() - rb != PKT_LEN) begin n_fail++; $display("FAIL gap_count: got %0d want %0d", rx_q.size() - rb, PKT_LEN); end
        for (int k = 0; k < PKT_LEN && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL gap_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
        end
        n_checks++; if (rb < rx_q.size() && rx_cyc[rb] != last_acc_cyc + 1) begin n_fail++; $display("FAIL gap_latency: cycle %0d want %0d", rx_cyc[rb], last_acc_cyc + 1); end
    endtask

    task automatic test_random();
        int rb = rx_q.size(); int eb = exp_q.size();
        int s0 = n_short_seen; int l0 = n_long_seen; int es0 = exp_short; int el0 = exp_long;
        for (int p = 0; p < 24; p++) begin
            int len;
            if ($urandom_range(0, 2) != 0) len = PKT_LEN;
            else if ($urandom_range(0, 1) == 1) len = $urandom_range(1, PKT_LEN - 1);
            else len = $urandom_range(PKT_LEN + 1, PKT_LEN + 4);
            send_pkt(len, 1'($urandom_range(0, 1)), 32'h0, 1'b1);
        end
        repeat (PKT_LEN + 3) @(negedge clock);
        n_checks++; if (rx_q.size() - rb != exp_q.size() - eb) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", rx_q.size() - rb, exp_q.size() - eb); end
        for (int k = 0; k < exp_q.size() - eb && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL rand_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
        end
        n_checks++; if (n_short_seen - s0 != exp_short - es0) begin n_fail++; $display("FAIL rand_short: got %0d want %0d", n_short_seen - s0, exp_short - es0); end
        n_checks++; if (n_long_seen - l0 != exp_long - el0) begin n_fail++; $display("FAIL rand_long: got %0d want %0d", n_long_seen - l0, exp_long - el0); end
        n_checks++; if (pkt_good !== CNT_W'(sat(exp_good))) begin n_fail++; $display("FAIL rand_pkt_good: got %0d want %0d", pkt_good, sat(exp_good)); end
        n_checks++; if (pkt_bad !== CNT_W'(sat(exp_bad))) begin n_fail++; $display("FAIL rand_pkt_bad: got %0d want %0d", pkt_bad, sat(exp_bad)); end
    endtask

    task automatic test_reset_mid_drain();
        int rb = rx_q.size(); int eb = exp_q.size(); int t = 0;
        send_pkt(PKT_LEN, 1'b0, 32'h0, 1'b1);
        while (rx_q.size() - rb < 4 && t < 50) begin @(negedge clock); t++; end
        n_checks++; if (rx_q.size() - rb != 4) begin n_fail++; $display("FAIL rst_drain_words: got %0d want 4", rx_q.size() - rb); end
        for (int k = 0; k < 4 && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL rst_drain_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
        end
        reset_n = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain_valid: got %b want 0", valid); end
        n_checks++; if (ifc.s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_drain_tready: got %b want 1", ifc.s_tready); end
        n_checks++; if (pkt_good !== '0 || pkt_bad !== '0) begin n_fail++; $display("FAIL rst_drain_cnt: got %0d/%0d want 0/0", pkt_good, pkt_bad); end
        exp_good = 0; exp_bad = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        rb = rx_q.size(); eb = exp_q.size();
        send_pkt(PKT_LEN, 1'b0, 32'h5000, 1'b0);
        repeat (PKT_LEN + 3) @(negedge clock);
        n_checks++; if (rx_q.size() - rb != PKT_LEN) begin n_fail++; $display("FAIL rst_follow_count: got %0d want %0d", rx_q.size() - rb, PKT_LEN); end
        for (int k = 0; k < PKT_LEN && rb + k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[rb + k] !== exp_q[eb + k]) begin n_fail++; $display("FAIL rst_follow_word[%0d]: got %h want %h", k, rx_q[rb + k], exp_q[eb + k]); end
        end
        n_checks++; if (pkt_good !== CNT_W'(1)) begin n_fail++; $display("FAIL rst_follow_good: got %0d want 1", pkt_good); end
    endtask

    initial begin
        ifc.s_tdata  = '0;
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        @(negedge clock);
        test_reset();
        test_good();
        test_back_to_back();
        test_short();
        test_long();
        test_gapped();
        test_random();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
